// File: rtl/oculink_axi_pkg.sv
// Shared types for the Oculink AXI write path: AW/B payloads and the
// write arbiter state encoding.
package oculink_axi_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  burst;
      logic [3:0]  id;
      logic [7:0]  len;
      logic [3:0]  region;
      logic [2:0]  size;
   } aw_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT_M0 = 2'd1,
      GRANT_M1 = 2'd2
   } wr_arb_state_e;

endpackage

// File: rtl/owner_fifo.sv
// 1-bit wide in-order FIFO recording which master owns each outstanding
// write burst; head selects the B-channel destination.
module owner_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       din,
   input  logic                       pop,
   output logic                       dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

   always_comb begin
      do_push  = push && (!full || pop);
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/oculink_wr_arbiter.sv
// Burst-atomic round-robin arbiter sharing one AXI write slave between the
// NVMe configurator (M0) and driver (M1); B responses follow issue order.
module oculink_wr_arbiter
   import oculink_axi_pkg::*;
#(
   parameter int MAX_OUT = 8,
   parameter int DATA_W  = 256
) (
   input  logic                   oculink_axi_clk,
   input  logic                   rstn,
   input  logic [31:0]            m0_awaddr,
   input  logic [1:0]             m0_awburst,
   input  logic [3:0]             m0_awid,
   input  logic [7:0]             m0_awlen,
   input  logic [3:0]             m0_awregion,
   input  logic [2:0]             m0_awsize,
   input  logic                   m0_awvalid,
   output logic                   m0_awready,
   input  logic [DATA_W-1:0]      m0_wdata,
   input  logic [DATA_W/8-1:0]    m0_wstrb,
   input  logic                   m0_wlast,
   input  logic                   m0_wvalid,
   output logic                   m0_wready,
   output logic [3:0]             m0_bid,
   output logic [1:0]             m0_bresp,
   output logic                   m0_bvalid,
   input  logic                   m0_bready,
   input  logic [31:0]            m1_awaddr,
   input  logic [1:0]             m1_awburst,
   input  logic [3:0]             m1_awid,
   input  logic [7:0]             m1_awlen,
   input  logic [3:0]             m1_awregion,
   input  logic [2:0]             m1_awsize,
   input  logic                   m1_awvalid,
   output logic                   m1_awready,
   input  logic [DATA_W-1:0]      m1_wdata,
   input  logic [DATA_W/8-1:0]    m1_wstrb,
   input  logic                   m1_wlast,
   input  logic                   m1_wvalid,
   output logic                   m1_wready,
   output logic [3:0]             m1_bid,
   output logic [1:0]             m1_bresp,
   output logic                   m1_bvalid,
   input  logic                   m1_bready,
   output logic [31:0]            s_awaddr,
   output logic [1:0]             s_awburst,
   output logic [3:0]             s_awid,
   output logic [7:0]             s_awlen,
   output logic [3:0]             s_awregion,
   output logic [2:0]             s_awsize,
   output logic                   s_awvalid,
   input  logic                   s_awready,
   output logic [DATA_W-1:0]      s_wdata,
   output logic [DATA_W/8-1:0]    s_wstrb,
   output logic                   s_wlast,
   output logic                   s_wvalid,
   input  logic                   s_wready,
   input  logic [3:0]             s_bid,
   input  logic [1:0]             s_bresp,
   input  logic                   s_bvalid,
   output logic                   s_bready,
   output logic [$clog2(MAX_OUT):0] outstanding,
   output logic                   err_orphan_b
);

   wr_arb_state_e state_q, state_d;
   logic          rr_q, rr_d;        // 1: M1 wins a tie
   logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic          err_orphan_q, err_orphan_d;

   aw_chan_t      m0_aw, m1_aw, sel_aw, aw_out;
   b_chan_t       s_b, m0_b, m1_b;
   logic          granted, gsel, req0, req1, pick;
   logic          aw_hs, w_last_hs, b_pop;
   logic          fifo_full, fifo_empty, fifo_head, route0, route1;

   assign m0_aw = '{addr: m0_awaddr, burst: m0_awburst, id: m0_awid,
                    len: m0_awlen, region: m0_awregion, size: m0_awsize};
   assign m1_aw = '{addr: m1_awaddr, burst: m1_awburst, id: m1_awid,
                    len: m1_awlen, region: m1_awregion, size: m1_awsize};
   assign s_b   = '{id: s_bid, resp: s_bresp};

   assign aw_hs     = s_awvalid && s_awready;
   assign w_last_hs = s_wvalid && s_wready && s_wlast;

   // Forward path: only the granted master reaches the slave, and a channel
   // whose flag is already set stays closed until the grant is released.
   always_comb begin
      granted    = (state_q != IDLE);
      gsel       = (state_q == GRANT_M1);
      sel_aw     = gsel ? m1_aw : m0_aw;
      aw_out     = granted ? sel_aw : '0;
      s_awvalid  = granted && !aw_done_q && (gsel ? m1_awvalid : m0_awvalid);
      s_wvalid   = granted && !w_done_q  && (gsel ? m1_wvalid  : m0_wvalid);
      s_wdata    = granted ? (gsel ? m1_wdata : m0_wdata) : '0;
      s_wstrb    = granted ? (gsel ? m1_wstrb : m0_wstrb) : '0;
      s_wlast    = granted && (gsel ? m1_wlast : m0_wlast);
      m0_awready = granted && !gsel && !aw_done_q && s_awready;
      m1_awready = granted &&  gsel && !aw_done_q && s_awready;
      m0_wready  = granted && !gsel && !w_done_q  && s_wready;
      m1_wready  = granted &&  gsel && !w_done_q  && s_wready;
   end

   assign s_awaddr   = aw_out.addr;
   assign s_awburst  = aw_out.burst;
   assign s_awid     = aw_out.id;
   assign s_awlen    = aw_out.len;
   assign s_awregion = aw_out.region;
   assign s_awsize   = aw_out.size;

   // Return path: the FIFO head names the owner; with nothing outstanding the
   // response is swallowed and flagged.
   always_comb begin
      route0    = !fifo_empty && !fifo_head;
      route1    = !fifo_empty &&  fifo_head;
      s_bready  = fifo_empty ? 1'b1 : (fifo_head ? m1_bready : m0_bready);
      m0_bvalid = route0 && s_bvalid;
      m1_bvalid = route1 && s_bvalid;
      m0_b      = route0 ? s_b : '0;
      m1_b      = route1 ? s_b : '0;
      b_pop     = s_bvalid && s_bready && !fifo_empty;
   end

   assign m0_bid   = m0_b.id;
   assign m0_bresp = m0_b.resp;
   assign m1_bid   = m1_b.id;
   assign m1_bresp = m1_b.resp;

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      req0         = m0_awvalid || m0_wvalid;
      req1         = m1_awvalid || m1_wvalid;
      pick         = (req0 && req1) ? rr_q : req1;
      err_orphan_d = err_orphan_q || (fifo_empty && s_bvalid);
      case (state_q)
         IDLE: begin
            if ((req0 || req1) && !fifo_full) begin
               state_d = pick ? GRANT_M1 : GRANT_M0;
               rr_d    = !pick;
            end
         end
         GRANT_M0, GRANT_M1: begin
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q  || w_last_hs;
            if (aw_done_d && w_done_d) begin
               state_d   = IDLE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge oculink_axi_clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         rr_q         <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         err_orphan_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   assign err_orphan_b = err_orphan_q;

   owner_fifo #(.DEPTH(MAX_OUT)) u_owner_fifo (
      .clk   (oculink_axi_clk),
      .rst_n (rstn),
      .push  (aw_hs),
      .din   (gsel),
      .pop   (b_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (outstanding)
   );

endmodule

// File: tb/tb_oculink_wr_arbiter.sv
// Bench for oculink_wr_arbiter: table of single bursts plus hand sequences for
// arbitration order, FIFO full, orphan B and reset mid-burst.
module tb_oculink_wr_arbiter;

   localparam int DATA_W  = 256;
   localparam int SW      = DATA_W / 8;
   localparam int MAX_OUT = 8;
   localparam int CW      = $clog2(MAX_OUT) + 1;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   logic [31:0]       m_awaddr[2];
   logic [1:0]        m_awburst[2];
   logic [3:0]        m_awid[2];
   logic [7:0]        m_awlen[2];
   logic [3:0]        m_awregion[2];
   logic [2:0]        m_awsize[2];
   logic              m_awvalid[2], m_awready[2];
   logic [DATA_W-1:0] m_wdata[2];
   logic [SW-1:0]     m_wstrb[2];
   logic              m_wlast[2], m_wvalid[2], m_wready[2];
   logic [3:0]        m_bid[2];
   logic [1:0]        m_bresp[2];
   logic              m_bvalid[2], m_bready[2];

   logic [31:0]       s_awaddr;
   logic [1:0]        s_awburst;
   logic [3:0]        s_awid;
   logic [7:0]        s_awlen;
   logic [3:0]        s_awregion;
   logic [2:0]        s_awsize;
   logic              s_awvalid, s_awready;
   logic [DATA_W-1:0] s_wdata;
   logic [SW-1:0]     s_wstrb;
   logic              s_wlast, s_wvalid, s_wready;
   logic [3:0]        s_bid;
   logic [1:0]        s_bresp;
   logic              s_bvalid, s_bready;
   logic [CW-1:0]     outstanding;
   logic              err_orphan_b;

   oculink_wr_arbiter #(.MAX_OUT(MAX_OUT), .DATA_W(DATA_W)) dut (
      .oculink_axi_clk(clk), .rstn(rstn),
      .m0_awaddr(m_awaddr[0]), .m0_awburst(m_awburst[0]), .m0_awid(m_awid[0]),
      .m0_awlen(m_awlen[0]), .m0_awregion(m_awregion[0]), .m0_awsize(m_awsize[0]),
      .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
      .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
      .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
      .m0_bid(m_bid[0]), .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
      .m1_awaddr(m_awaddr[1]), .m1_awburst(m_awburst[1]), .m1_awid(m_awid[1]),
      .m1_awlen(m_awlen[1]), .m1_awregion(m_awregion[1]), .m1_awsize(m_awsize[1]),
      .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
      .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
      .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
      .m1_bid(m_bid[1]), .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
      .s_awaddr(s_awaddr), .s_awburst(s_awburst), .s_awid(s_awid), .s_awlen(s_awlen),
      .s_awregion(s_awregion), .s_awsize(s_awsize), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .outstanding(outstanding), .err_orphan_b(err_orphan_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct { int m; logic [31:0] addr; logic [3:0] id; logic [7:0] len; } exp_aw_t;
   typedef struct { int m; logic [DATA_W-1:0] data; logic last; } exp_w_t;
   exp_aw_t exp_aw_q[$];
   exp_w_t  exp_w_q[$];
   int      exp_b_q[$];

   typedef struct {
      int m; logic [31:0] addr; logic [3:0] id; logic [7:0] len; int aw_dly; logic [1:0] bresp;
      int exp_aw_wait; logic [CW-1:0] exp_out; logic [1:0] exp_bv;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] wpat(input logic [31:0] addr, input int b);
      return {8{addr ^ 32'(b)}};
   endfunction

   task automatic expect_burst(input int m, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
      exp_aw_t a;
      exp_w_t  w;
      a.m = m; a.addr = addr; a.id = id; a.len = len;
      exp_aw_q.push_back(a);
      for (int b = 0; b <= int'(len); b++) begin
         w.m = m; w.data = wpat(addr, b); w.last = (b == int'(len));
         exp_w_q.push_back(w);
      end
   endtask

   // aw_wait = negedges with AW valid but not accepted
   task automatic drive_burst(input int m, input logic [31:0] addr, input logic [3:0] id,
                              input logic [7:0] len, input int aw_dly, output int aw_wait);
      int aw_n;
      aw_n = 0;
      fork
         begin
            bit hs;
            hs = 0;
            repeat (aw_dly + 1) @(posedge clk);
            #1;
            m_awaddr[m] = addr; m_awid[m] = id; m_awlen[m] = len;
            m_awburst[m] = 2'b01; m_awsize[m] = 3'd5; m_awregion[m] = id;
            m_awvalid[m] = 1'b1;
            while (!hs && aw_n < 200) begin
               @(negedge clk); hs = m_awready[m];
               @(posedge clk); if (!hs) aw_n++;
            end
            #1 m_awvalid[m] = 1'b0;
            check("aw_hs_in_budget", 256'(hs), 1);
         end
         begin
            @(posedge clk);
            #1;
            for (int b = 0; b <= int'(len); b++) begin
               bit hs;
               int n;
               hs = 0; n = 0;
               m_wdata[m] = wpat(addr, b); m_wstrb[m] = '1;
               m_wlast[m] = (b == int'(len)); m_wvalid[m] = 1'b1;
               while (!hs && n < 200) begin
                  @(negedge clk); hs = m_wready[m];
                  @(posedge clk); n++;
               end
               #1;
               if (!hs) check("w_hs_in_budget", 256'(hs), 1);
            end
            m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
         end
      join
      aw_wait = aw_n;
   endtask

   task automatic return_b(input logic [3:0] bid, input logic [1:0] resp, output logic [1:0] seen);
      int own;
      bit hs;
      int n;
      hs = 0; n = 0; seen = 2'b00;
      @(posedge clk);
      #1 s_bvalid = 1'b1; s_bid = bid; s_bresp = resp;
      own = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : -1;
      check("b_owner_expected", 256'(own >= 0), 1);
      while (!hs && n < 50) begin
         @(negedge clk);
         if (n == 0) begin
            seen = {m_bvalid[1], m_bvalid[0]};
            check("b_route", seen, (own == 1) ? 2'b10 : 2'b01);
            if (own >= 0) check("b_id_resp", {m_bid[own], m_bresp[own]}, {bid, resp});
         end
         hs = s_bready;
         @(posedge clk); n++;
      end
      #1 s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
      check("b_hs_in_budget", 256'(hs), 1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_valids"}, {s_awvalid, s_wvalid, m_awready[0], m_awready[1], m_wready[0],
                               m_wready[1], m_bvalid[0], m_bvalid[1]}, 8'h00);
      check({tag, "_bready_out_err"}, {s_bready, outstanding, err_orphan_b}, {1'b1, CW'(0), 1'b0});
      check({tag, "_payload_zero"}, 256'(|{s_awaddr, s_awburst, s_awid, s_awlen, s_awregion, s_awsize,
                                          s_wdata, s_wstrb, s_wlast, m_bid[0], m_bid[1],
                                          m_bresp[0], m_bresp[1]}), 0);
   endtask

   // scoreboard side: every slave-side handshake must match the next expectation
   always @(negedge clk) begin
      if (rstn && s_awvalid && s_awready) begin
         if (exp_aw_q.size() == 0) check("aw_unexpected", exp_aw_q.size(), 1);
         else begin
            exp_aw_t e;
            e = exp_aw_q.pop_front();
            check("aw_payload", {s_awaddr, s_awid, s_awlen}, {e.addr, e.id, e.len});
            check("aw_source", m_awready[e.m], 1);
            exp_b_q.push_back(e.m);
         end
      end
      if (rstn && s_wvalid && s_wready) begin
         if (exp_w_q.size() == 0) check("w_unexpected", exp_w_q.size(), 1);
         else begin
            exp_w_t e;
            e = exp_w_q.pop_front();
            check("w_data", s_wdata, e.data);
            check("w_last_src", {s_wlast, m_wready[e.m]}, {e.last, 1'b1});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int w0, w1;
      logic [1:0] seen;
      bit blocked;
      bit hs_aw, hs_w;
      int beats, cyc;

      vecs[0] = '{0, 32'h1000, 4'h1, 8'd0, 0, 2'b00, 1, CW'(1), 2'b01};
      vecs[1] = '{1, 32'h2000, 4'h2, 8'd3, 0, 2'b10, 1, CW'(1), 2'b10};
      vecs[2] = '{1, 32'h2400, 4'h3, 8'd1, 3, 2'b00, 0, CW'(1), 2'b10};
      vecs[3] = '{0, 32'h1800, 4'h4, 8'd2, 2, 2'b11, 0, CW'(1), 2'b01};
      vecs[4] = '{1, 32'h2800, 4'h5, 8'd0, 0, 2'b01, 1, CW'(1), 2'b10};

      for (int i = 0; i < 2; i++) begin
         m_awaddr[i] = '0; m_awburst[i] = '0; m_awid[i] = '0; m_awlen[i] = '0;
         m_awregion[i] = '0; m_awsize[i] = '0; m_awvalid[i] = 1'b0;
         m_wdata[i] = '0; m_wstrb[i] = '0; m_wlast[i] = 1'b0; m_wvalid[i] = 1'b0;
         m_bready[i] = 1'b1;
      end
      s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;

      #2 rstn = 1'b0;
      #1 check_reset_vals("reset");
      @(negedge clk); @(negedge clk) rstn = 1'b1;

      foreach (vecs[i]) begin
         expect_burst(vecs[i].m, vecs[i].addr, vecs[i].id, vecs[i].len);
         drive_burst(vecs[i].m, vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].aw_dly, w0);
         check($sformatf("vec%0d_aw_wait", i), 256'(w0), 256'(vecs[i].exp_aw_wait));
         check($sformatf("vec%0d_outstanding", i), outstanding, vecs[i].exp_out);
         return_b(vecs[i].id, vecs[i].bresp, seen);
         check($sformatf("vec%0d_bvalid", i), seen, vecs[i].exp_bv);
         check($sformatf("vec%0d_drained", i), outstanding, 0);
      end

      // both request at reset release: M0 first, one bubble, then M1
      @(negedge clk) rstn = 1'b0;
      @(negedge clk) rstn = 1'b1;
      expect_burst(0, 32'h4000, 4'h6, 8'd3);
      expect_burst(1, 32'h5000, 4'h7, 8'd3);
      fork
         drive_burst(0, 32'h4000, 4'h6, 8'd3, 0, w0);
         drive_burst(1, 32'h5000, 4'h7, 8'd3, 0, w1);
      join
      check("simul_m0_wait", 256'(w0), 1);
      check("simul_m1_wait", 256'(w1), 6);
      check("simul_outstanding", outstanding, 2);
      return_b(4'h6, 2'b00, seen);
      check("simul_b0", seen, 2'b01);
      return_b(4'h7, 2'b00, seen);
      check("simul_b1", seen, 2'b10);

      // fill the owner FIFO from M1, then M0 must wait for a B
      for (int k = 0; k < MAX_OUT; k++) begin
         expect_burst(1, 32'h8000 + 32'(k * 16), 4'(k), 8'd0);
         drive_burst(1, 32'h8000 + 32'(k * 16), 4'(k), 8'd0, 0, w1);
      end
      check("full_outstanding", outstanding, MAX_OUT);
      expect_burst(0, 32'h9000, 4'hA, 8'd0);
      blocked = 1'b0;
      fork
         drive_burst(0, 32'h9000, 4'hA, 8'd0, 0, w0);
         begin
            repeat (6) begin
               @(negedge clk);
               if (m_awready[0] || m_wready[0] || s_awvalid) blocked = 1'b1;
            end
            check("full_no_grant", 256'(blocked), 0);
            return_b(4'h0, 2'b00, seen);
            check("full_first_b_m1", seen, 2'b10);
         end
      join
      check("full_m0_after_b", outstanding, MAX_OUT);
      for (int k = 0; k < MAX_OUT; k++) return_b(4'(k), 2'b00, seen);
      check("full_last_b_m0", seen, 2'b01);
      check("full_drained", outstanding, 0);

      // orphan B with nothing outstanding
      @(posedge clk);
      #1 s_bvalid = 1'b1; s_bid = 4'h9;
      @(negedge clk);
      check("orphan_route", {s_bready, m_bvalid[0], m_bvalid[1]}, 3'b100);
      @(posedge clk);
      #1 s_bvalid = 1'b0; s_bid = '0;
      check("orphan_flag", err_orphan_b, 1);

      // reset after two of four W beats
      expect_burst(0, 32'hA000, 4'hB, 8'd3);
      @(posedge clk);
      #1;
      m_awaddr[0] = 32'hA000; m_awid[0] = 4'hB; m_awlen[0] = 8'd3; m_awvalid[0] = 1'b1;
      m_wdata[0] = wpat(32'hA000, 0); m_wstrb[0] = '1; m_wlast[0] = 1'b0; m_wvalid[0] = 1'b1;
      beats = 0; cyc = 0;
      while (beats < 2 && cyc < 50) begin
         @(negedge clk); hs_aw = m_awready[0]; hs_w = m_wready[0];
         @(posedge clk); #1; cyc++;
         if (hs_aw) m_awvalid[0] = 1'b0;
         if (hs_w) begin beats++; m_wdata[0] = wpat(32'hA000, beats); end
      end
      check("mid_two_beats", 256'(beats), 2);
      check("mid_pre_state", {s_wvalid, outstanding, err_orphan_b}, {1'b1, CW'(1), 1'b1});
      #2 rstn = 1'b0;
      #1 check_reset_vals("mid_reset");
      m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
      exp_w_q.delete(); exp_b_q.delete(); exp_aw_q.delete();
      @(negedge clk) rstn = 1'b1;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
